// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/mem/writeback
// and drives the datapath enables and selects. Datapath registers live outside this block.
module multicycle_ctrl #(
  parameter int INSTRET_W     = 32,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [2:0]           imm_sel,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  // Memory handshake: mem_req is held high until the cycle mem_ready=1 completes the
  // request; mem_ready is ignored whenever mem_req=0.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam int HOLD_W = $clog2(RESET_PC_HOLD + 1);

  state_t            state, nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              retire;

  logic [6:0] opcode;
  logic is_lui, is_auipc, is_jal, is_jalr, is_load, is_store, is_branch, is_opimm, is_op;
  logic legal;

  assign opcode    = instr[6:0];
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_opimm  = (opcode == OP_IMM);
  assign is_op     = (opcode == OP_OP);
  assign legal     = is_lui | is_auipc | is_jal | is_jalr | is_load | is_store |
                     is_branch | is_opimm | is_op;

  assign state_o = state;

  // State register plus the IDLE hold counter and retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && nxt == S_IDLE) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                                  hold_cnt <= '0;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (hold_cnt == HOLD_W'(RESET_PC_HOLD - 1)) nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_load || is_store) nxt = S_MEM;
        else if (is_branch)      nxt = S_FETCH;
        else                     nxt = S_WB;
      end
      S_MEM:    if (mem_ready) nxt = is_store ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    imm_sel   = 3'd0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    illegal   = 1'b0;
    retire    = 1'b0;

    // Format-derived selects stay valid for the whole life of the instruction.
    if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
      if (is_lui || is_auipc)                  imm_sel = IMM_U;
      else if (is_jal)                         imm_sel = IMM_J;
      else if (is_store)                       imm_sel = IMM_S;
      else if (is_branch)                      imm_sel = IMM_B;
      else                                     imm_sel = IMM_I;
      alu_src_a = is_auipc | is_jal | is_branch;
      alu_src_b = ~is_op;
    end

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready && is_store) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = (instr[11:7] != 5'd0);
        pc_we  = 1'b1;
        pc_sel = is_jal | is_jalr;
        retire = 1'b1;
        if (is_load)                wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        else if (is_lui)            wb_sel = 2'd3;
        else                        wb_sel = 2'd0;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: hand-computed control values per state for
// load/store/branch/jal/lui/op instructions, async reset mid-MEM and the illegal trap.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, ir_we, pc_we, pc_sel;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b, rf_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state_o;
  logic [31:0] instret;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl #(.INSTRET_W(32), .RESET_PC_HOLD(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .imm_sel      (imm_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .state_o      (state_o),
    .instret      (instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one full cycle; we always sit just after a negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // From FETCH: hold `waits` cycles without mem_ready, then complete; ends in DECODE.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    instr = word;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("fetch_state", state_o, 1);
      chk("fetch_req", mem_req, 1);
      chk("fetch_irwe_wait", ir_we, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("fetch_state", state_o, 1);
    chk("fetch_irwe_done", ir_we, 1);
    chk("fetch_we", mem_we, 0);
    tick();
    mem_ready = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    instr = 32'h0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", illegal, 0);

    // release; one IDLE hold cycle then FETCH
    rst = 1'b1;
    #1;
    chk("idle_state", state_o, 0);
    tick();

    // lw x6,-4(x9), fetch delayed 2 cycles
    do_fetch(32'hFFC4A303, 2);
    chk("lw_dec_state", state_o, 2);
    chk("lw_dec_imm", imm_sel, 0);
    chk("lw_dec_srcb", alu_src_b, 1);
    tick();
    chk("lw_ex_state", state_o, 3);
    chk("lw_ex_srca", alu_src_a, 0);
    chk("lw_ex_pcwe", pc_we, 0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("lw_mem_state", state_o, 4);
    chk("lw_mem_req", mem_req, 1);
    chk("lw_mem_we", mem_we, 0);
    chk("lw_mem_pcwe", pc_we, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("lw_wb_state", state_o, 5);
    chk("lw_wb_rfwe", rf_we, 1);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_pcwe", pc_we, 1);
    chk("lw_wb_pcsel", pc_sel, 0);
    chk("lw_instret_before", instret, 0);
    tick();
    chk("lw_back_fetch", state_o, 1);
    chk("lw_instret", instret, 1);

    // sw x6,8(x9): 4 cycles
    do_fetch(32'h0064A423, 0);
    chk("sw_dec_imm", imm_sel, 1);
    chk("sw_dec_rfwe", rf_we, 0);
    tick();
    chk("sw_ex_state", state_o, 3);
    chk("sw_ex_rfwe", rf_we, 0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("sw_mem_state", state_o, 4);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_pcwe", pc_we, 1);
    chk("sw_mem_pcsel", pc_sel, 0);
    chk("sw_mem_rfwe", rf_we, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("sw_back_fetch", state_o, 1);
    chk("sw_instret", instret, 2);

    // beq taken / not taken: 3 cycles each
    for (int t = 1; t >= 0; t--) begin
      do_fetch(32'hFE420AE3, 0);
      chk("beq_dec_imm", imm_sel, 2);
      chk("beq_dec_srca", alu_src_a, 1);
      tick();
      branch_taken = (t == 1);
      #1;
      chk("beq_ex_state", state_o, 3);
      chk("beq_ex_pcwe", pc_we, 1);
      chk("beq_ex_pcsel", pc_sel, t);
      chk("beq_ex_rfwe", rf_we, 0);
      tick();
      branch_taken = 1'b0;
      chk("beq_back_fetch", state_o, 1);
      chk("beq_instret", instret, (t == 1) ? 3 : 4);
    end

    // jal x1,8 then jal x0,8
    for (int r = 0; r < 2; r++) begin
      do_fetch((r == 0) ? 32'h008000EF : 32'h0080006F, 0);
      chk("jal_dec_imm", imm_sel, 4);
      chk("jal_dec_srca", alu_src_a, 1);
      tick();
      chk("jal_ex_pcwe", pc_we, 0);
      tick();
      chk("jal_wb_state", state_o, 5);
      chk("jal_wb_rfwe", rf_we, (r == 0) ? 1 : 0);
      chk("jal_wb_sel", wb_sel, 2);
      chk("jal_wb_pcsel", pc_sel, 1);
      chk("jal_wb_pcwe", pc_we, 1);
      tick();
      chk("jal_instret", instret, 5 + r);
    end

    // lui x5 (wb_sel=IMM) and add x1,x2,x3 (alu_src_b=0, wb_sel=ALU)
    do_fetch(32'h123452B7, 0);
    chk("lui_dec_imm", imm_sel, 3);
    chk("lui_dec_srca", alu_src_a, 0);
    tick();
    tick();
    chk("lui_wb_sel", wb_sel, 3);
    chk("lui_wb_pcsel", pc_sel, 0);
    tick();
    do_fetch(32'h003100B3, 0);
    chk("add_dec_srcb", alu_src_b, 0);
    chk("add_dec_imm", imm_sel, 0);
    tick();
    tick();
    chk("add_wb_sel", wb_sel, 0);
    chk("add_wb_rfwe", rf_we, 1);
    tick();
    chk("add_instret", instret, 8);

    // reset mid-MEM on a load held by mem_ready=0
    do_fetch(32'hFFC4A303, 0);
    tick();
    tick();
    chk("rmem_state", state_o, 4);
    chk("rmem_req_before", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("rmem_req_async", mem_req, 0);
    chk("rmem_state_async", state_o, 0);
    chk("rmem_instret_async", instret, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmem_idle_hold", state_o, 0);
    tick();
    chk("rmem_fetch", state_o, 1);

    // illegal opcode -> TRAP, sticky until reset
    do_fetch(32'h00000000, 0);
    chk("trap_dec_state", state_o, 2);
    tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = (i % 2 == 0);
      #1;
      chk("trap_state", state_o, 6);
      chk("trap_illegal", illegal, 1);
      chk("trap_req", mem_req, 0);
      tick();
    end
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_state", state_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with the unified memory port. It drives the datapath selects, including imm_sel for ImmGen. Datapath registers (IR, PC, regfile) live outside this block; this block only issues their enables and selects.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter
RESET_PC_HOLD, 1, number of IDLE cycles after reset release before the first FETCH (minimum 1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
instr  in  32  IR contents; stable from DECODE onward
mem_ready  in  1  memory completes the current request this cycle
branch_taken  in  1  comparator result for the current B-type instruction
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = store, valid with mem_req
ir_we  out  1  load IR from the memory read data
pc_we  out  1  update PC
pc_sel  out  1  PC source: 0 = PC+4, 1 = ALU result
imm_sel  out  3  ImmGen format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J
alu_src_a  out  1  ALU A source: 0 = rs1, 1 = PC
alu_src_b  out  1  ALU B source: 0 = rs2, 1 = immediate
rf_we  out  1  regfile write enable
wb_sel  out  2  writeback source: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM
illegal  out  1  sticky illegal-opcode flag
state_o  out  3  current state, for debug
instret  out  INSTRET_W  count of retired instructions

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. The state register is the only storage apart from the IDLE hold counter and instret.
- Reset (rst=0, asynchronous): state=IDLE, instret=0, illegal=0. All control outputs read 0 immediately, not at the next clock edge. This applies if rst asserts in any state, including mid-MEM with mem_req high.
- IDLE: all outputs 0. After RESET_PC_HOLD cycles with rst=1, go to FETCH.
- FETCH: mem_req=1, mem_we=0. Stay while mem_ready=0. When mem_ready=1: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: decode instr[6:0] as follows.
  - LUI 0110111 and AUIPC 0010111: imm_sel=U.
  - JAL 1101111: imm_sel=J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: imm_sel=I.
  - STORE 0100011: imm_sel=S.
  - BRANCH 1100011: imm_sel=B.
  - OP 0110011: imm_sel=0 (don't-care).
  - Any other opcode: go to TRAP. Otherwise go to EXEC.
- imm_sel and the alu_src selects are combinational from instr in DECODE, EXEC, MEM and WB. They are 0 in all other states.
- EXEC, operand selects:
  - alu_src_a=1 for AUIPC, JAL, BRANCH.
  - alu_src_b=1 for all formats except OP.
- EXEC, next state:
  - LOAD or STORE: go to MEM.
  - BRANCH: pc_we=1, pc_sel=branch_taken, retire, go to FETCH.
  - All others: go to WB.
- MEM: mem_req=1, mem_we=1 for STORE. Stay while mem_ready=0.
  - STORE with mem_ready=1: pc_we=1, pc_sel=0, retire, go to FETCH.
  - LOAD with mem_ready=1: go to WB.
- WB: rf_we=1 unless instr[11:7]==0. pc_we=1, retire, go to FETCH.
  - pc_sel=1 for JAL/JALR, else 0.
  - wb_sel: MEM for LOAD, PC+4 for JAL/JALR, IMM for LUI, ALU otherwise.
- Retire: instret increments by 1 in the same cycle as the final pc_we. It wraps modulo 2^INSTRET_W.
- TRAP: illegal=1 and all other outputs 0. Remains there until reset.
- Latencies with zero memory wait: ALU/JAL/LUI = 4 cycles; BRANCH = 3; STORE = 4; LOAD = 5. Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset mid-MEM: LOAD held in MEM with mem_ready=0, assert rst=0 → mem_req drops to 0 without a clock edge; state_o=0 and instret=0; FETCH occurs after release plus RESET_PC_HOLD cycles.
- instr=0xFFC4A303 (lw x6,-4(x9)), mem_ready delayed 2 cycles in FETCH:
  - FETCH holds 3 cycles, with ir_we=1 only in the last one.
  - imm_sel=0 and alu_src_b=1; MEM shows mem_req=1, mem_we=0.
  - WB shows rf_we=1, wb_sel=1, pc_we=1, pc_sel=0.
  - instret goes 0→1.
- instr=0x0064A423 (sw x6,8(x9)): imm_sel=1; MEM shows mem_we=1; rf_we stays 0 throughout; pc_we=1 on mem_ready; 4 cycles total.
- instr=0xFE420AE3 (beq), branch_taken=1 → imm_sel=2, alu_src_a=1, EXEC pc_we=1, pc_sel=1, back to FETCH after 3 cycles. Repeat with branch_taken=0 → pc_sel=0.
- instr=0x008000EF (jal x1,8) → imm_sel=4; WB shows rf_we=1, wb_sel=2, pc_sel=1. Repeat with rd=x0 (0x0080006F) → rf_we=0.
- instr=0x00000000 → TRAP; illegal=1; mem_req stays 0 for 10+ cycles; only reset clears it.
